// File: rtl/sram_port_arbiter.sv
// Arbitrates an instruction-fetch port and a load/store port onto one single-port SRAM.
// Data has priority; a saturating starve counter guarantees fetch progress.
module sram_port_arbiter #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        resetn,
   // fetch port
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   input  logic        inst_cancel,
   output logic        inst_gnt,
   output logic        inst_rvalid,
   output logic [31:0] inst_rdata,
   // load/store port
   input  logic        data_req,
   input  logic [3:0]  data_we,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_gnt,
   output logic        data_rvalid,
   output logic [31:0] data_rdata,
   // shared SRAM
   output logic        sram_en,
   output logic [3:0]  sram_we,
   output logic [31:0] sram_addr,
   output logic [31:0] sram_wdata,
   input  logic [31:0] sram_rdata
);

   localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_MAX);

   typedef enum logic [1:0] {
      IDLE,
      RESP_INST,
      RESP_DATA
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_starve_cnt;
   logic [3:0] w_starve_nxt;
   logic       w_inst_prio;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its inputs, regardless of process ordering.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state      <= IDLE;
         r_starve_cnt <= 4'd0;
      end else begin
         r_state      <= w_state_nxt;
         r_starve_cnt <= w_starve_nxt;
      end
   end

   // NOTE: every output of this block gets a default first, so no path
   // through the if/case tree can leave a value held (no latch inferred).
   always_comb begin
      inst_gnt     = 1'b0;
      data_gnt     = 1'b0;
      inst_rvalid  = 1'b0;
      data_rvalid  = 1'b0;
      sram_en      = 1'b0;
      sram_we      = 4'd0;
      sram_addr    = 32'd0;
      sram_wdata   = 32'd0;
      w_state_nxt  = IDLE;
      w_starve_nxt = r_starve_cnt;
      w_inst_prio  = inst_req && (r_starve_cnt == C_STARVE_MAX);

      // Gating with resetn keeps every strobe low for the whole reset window,
      // not just after the first edge.
      if (resetn) begin
         if (inst_req && (!data_req || w_inst_prio)) begin
            inst_gnt  = 1'b1;
            sram_en   = 1'b1;
            sram_addr = inst_addr;
         end else if (data_req) begin
            data_gnt   = 1'b1;
            sram_en    = 1'b1;
            sram_we    = data_we;
            sram_addr  = data_addr;
            sram_wdata = data_wdata;
         end

         case (r_state)
            RESP_INST: inst_rvalid = ~inst_cancel;
            RESP_DATA: data_rvalid = 1'b1;
            default:   ;
         endcase
      end

      if (inst_gnt) begin
         w_state_nxt = RESP_INST;
      end else if (data_gnt && (data_we == 4'd0)) begin
         w_state_nxt = RESP_DATA;
      end

      if (!inst_req || inst_gnt) begin
         w_starve_nxt = 4'd0;
      end else if (data_gnt && (r_starve_cnt != C_STARVE_MAX)) begin
         w_starve_nxt = r_starve_cnt + 4'd1;
      end
   end

   assign inst_rdata = sram_rdata;
   assign data_rdata = sram_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: one task per scenario, hand-computed expectations.
// The SRAM model returns (addr ^ 32'hA5A5A5A5) one cycle after a read enable.
module tb_sram_port_arbiter;

   logic        clk;
   logic        resetn;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_cancel;
   logic        inst_gnt;
   logic        inst_rvalid;
   logic [31:0] inst_rdata;
   logic        data_req;
   logic [3:0]  data_we;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_gnt;
   logic        data_rvalid;
   logic [31:0] data_rdata;
   logic        sram_en;
   logic [3:0]  sram_we;
   logic [31:0] sram_addr;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata;

   int n_vec;
   int n_err;

   sram_port_arbiter #(.STARVE_MAX(4)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .inst_req    (inst_req),
      .inst_addr   (inst_addr),
      .inst_cancel (inst_cancel),
      .inst_gnt    (inst_gnt),
      .inst_rvalid (inst_rvalid),
      .inst_rdata  (inst_rdata),
      .data_req    (data_req),
      .data_we     (data_we),
      .data_addr   (data_addr),
      .data_wdata  (data_wdata),
      .data_gnt    (data_gnt),
      .data_rvalid (data_rvalid),
      .data_rdata  (data_rdata),
      .sram_en     (sram_en),
      .sram_we     (sram_we),
      .sram_addr   (sram_addr),
      .sram_wdata  (sram_wdata),
      .sram_rdata  (sram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (sram_en && (sram_we == 4'd0)) sram_rdata <= sram_addr ^ 32'hA5A5A5A5;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      inst_req    = 1'b0;
      inst_addr   = 32'd0;
      inst_cancel = 1'b0;
      data_req    = 1'b0;
      data_we     = 4'd0;
      data_addr   = 32'd0;
      data_wdata  = 32'd0;
   endtask

   task automatic test_reset();
      resetn     = 1'b0;
      sram_rdata = 32'd0;
      idle();
      inst_req   = 1'b1;
      data_req   = 1'b1;
      inst_addr  = 32'h1234_5678;
      data_addr  = 32'h0000_0ABC;
      data_wdata = 32'hFFFF_FFFF;
      data_we    = 4'hF;
      repeat (3) tick();
      #3;
      n_vec++;
      if ({inst_gnt, data_gnt, sram_en, sram_we, inst_rvalid, data_rvalid} !== 9'd0) begin
         n_err++;
         $display("FAIL reset_strobes: got %b want 0",
                  {inst_gnt, data_gnt, sram_en, sram_we, inst_rvalid, data_rvalid});
      end
      n_vec++;
      if ({sram_addr, sram_wdata} !== 64'd0) begin
         n_err++;
         $display("FAIL reset_bus: got addr=%h wdata=%h want 0", sram_addr, sram_wdata);
      end
      idle();
      tick();
      resetn = 1'b1;
      tick();
   endtask

   task automatic test_inst_only();
      idle();
      inst_req  = 1'b1;
      inst_addr = 32'h1C00_0000;
      #3;
      n_vec++;
      if ({inst_gnt, data_gnt, sram_en, sram_we} !== 7'b1_0_1_0000) begin
         n_err++;
         $display("FAIL inst_only_gnt: got %b want 1010000", {inst_gnt, data_gnt, sram_en, sram_we});
      end
      n_vec++;
      if (sram_addr !== 32'h1C00_0000) begin
         n_err++;
         $display("FAIL inst_only_addr: got %h want 1c000000", sram_addr);
      end
      tick();
      idle();
      #3;
      n_vec++;
      if ({inst_rvalid, data_rvalid, inst_rdata} !== {2'b10, 32'hB9A5_A5A5}) begin
         n_err++;
         $display("FAIL inst_only_resp: got rv=%b%b rdata=%h want 10 b9a5a5a5",
                  inst_rvalid, data_rvalid, inst_rdata);
      end
      tick();
   endtask

   task automatic test_contention();
      idle();
      inst_req  = 1'b1;
      inst_addr = 32'h1C00_0004;
      data_req  = 1'b1;
      data_addr = 32'h0000_0080;
      #3;
      n_vec++;
      if ({inst_gnt, data_gnt, sram_addr} !== {2'b01, 32'h0000_0080}) begin
         n_err++;
         $display("FAIL contention_c0: got gnt=%b%b addr=%h want 01 00000080",
                  inst_gnt, data_gnt, sram_addr);
      end
      tick();
      data_req = 1'b0;
      #3;
      n_vec++;
      if ({data_rvalid, data_rdata} !== {1'b1, 32'hA5A5_A525}) begin
         n_err++;
         $display("FAIL contention_data_resp: got rv=%b rdata=%h want 1 a5a5a525",
                  data_rvalid, data_rdata);
      end
      n_vec++;
      if ({inst_gnt, data_gnt, sram_addr} !== {2'b10, 32'h1C00_0004}) begin
         n_err++;
         $display("FAIL contention_c1: got gnt=%b%b addr=%h want 10 1c000004",
                  inst_gnt, data_gnt, sram_addr);
      end
      tick();
      idle();
      #3;
      n_vec++;
      if ({inst_rvalid, data_rvalid, inst_rdata} !== {2'b10, 32'hB9A5_A5A1}) begin
         n_err++;
         $display("FAIL contention_inst_resp: got rv=%b%b rdata=%h want 10 b9a5a5a1",
                  inst_rvalid, data_rvalid, inst_rdata);
      end
      tick();
   endtask

   task automatic test_starvation();
      logic [3:0] exp_v;
      logic [3:0] got_v;
      idle();
      tick();
      inst_req  = 1'b1;
      inst_addr = 32'h1C00_0010;
      data_req  = 1'b1;
      data_addr = 32'h0000_0200;
      for (int i = 0; i < 10; i++) begin
         #3;
         exp_v = {(i == 4 || i == 9), !(i == 4 || i == 9), (i == 5), (i >= 1 && i != 5)};
         got_v = {inst_gnt, data_gnt, inst_rvalid, data_rvalid};
         n_vec++;
         if (got_v !== exp_v) begin
            n_err++;
            $display("FAIL starve_cycle%0d: got {ig,dg,irv,drv}=%b want %b", i, got_v, exp_v);
         end
         tick();
      end
      idle();
      #3;
      n_vec++;
      if ({inst_rvalid, data_rvalid} !== 2'b10) begin
         n_err++;
         $display("FAIL starve_tail: got rv=%b%b want 10", inst_rvalid, data_rvalid);
      end
      tick();
   endtask

   task automatic test_store();
      idle();
      data_req   = 1'b1;
      data_we    = 4'b0011;
      data_addr  = 32'h0000_0100;
      data_wdata = 32'hDEAD_BEEF;
      #3;
      n_vec++;
      if ({data_gnt, sram_en, sram_we, sram_addr, sram_wdata} !==
          {2'b11, 4'b0011, 32'h0000_0100, 32'hDEAD_BEEF}) begin
         n_err++;
         $display("FAIL store_issue: got gnt=%b en=%b we=%b addr=%h wdata=%h want 1 1 0011 00000100 deadbeef",
                  data_gnt, sram_en, sram_we, sram_addr, sram_wdata);
      end
      tick();
      idle();
      #3;
      n_vec++;
      if ({inst_rvalid, data_rvalid} !== 2'b00) begin
         n_err++;
         $display("FAIL store_no_resp: got rv=%b%b want 00", inst_rvalid, data_rvalid);
      end
      tick();
   endtask

   task automatic test_cancel();
      idle();
      inst_req  = 1'b1;
      inst_addr = 32'h1C00_0020;
      tick();
      inst_addr   = 32'h1C00_0024;
      inst_cancel = 1'b1;
      #3;
      n_vec++;
      if ({inst_rvalid, inst_gnt, sram_addr} !== {2'b01, 32'h1C00_0024}) begin
         n_err++;
         $display("FAIL cancel_c1: got rv=%b gnt=%b addr=%h want 0 1 1c000024",
                  inst_rvalid, inst_gnt, sram_addr);
      end
      tick();
      idle();
      #3;
      n_vec++;
      if ({inst_rvalid, inst_rdata} !== {1'b1, 32'hB9A5_A581}) begin
         n_err++;
         $display("FAIL cancel_c2: got rv=%b rdata=%h want 1 b9a5a581", inst_rvalid, inst_rdata);
      end
      tick();
   endtask

   task automatic test_reset_mid_read();
      idle();
      data_req  = 1'b1;
      data_addr = 32'h0000_0040;
      #3;
      n_vec++;
      if (data_gnt !== 1'b1) begin
         n_err++;
         $display("FAIL rst_mid_gnt: got %b want 1", data_gnt);
      end
      resetn = 1'b0;
      #1;
      n_vec++;
      if ({data_gnt, sram_en, sram_we, data_rvalid, sram_addr} !== 39'd0) begin
         n_err++;
         $display("FAIL rst_mid_immediate: got gnt=%b en=%b we=%b rv=%b addr=%h want all 0",
                  data_gnt, sram_en, sram_we, data_rvalid, sram_addr);
      end
      tick();
      n_vec++;
      if ({data_rvalid, inst_rvalid, data_gnt, inst_gnt} !== 4'd0) begin
         n_err++;
         $display("FAIL rst_mid_dropped: got %b want 0000",
                  {data_rvalid, inst_rvalid, data_gnt, inst_gnt});
      end
      resetn    = 1'b1;
      data_addr = 32'h0000_0044;
      #3;
      n_vec++;
      if ({data_gnt, data_rvalid} !== 2'b10) begin
         n_err++;
         $display("FAIL rst_mid_resume_gnt: got gnt=%b rv=%b want 1 0", data_gnt, data_rvalid);
      end
      tick();
      idle();
      #3;
      n_vec++;
      if ({data_rvalid, data_rdata} !== {1'b1, 32'hA5A5_A5E1}) begin
         n_err++;
         $display("FAIL rst_mid_resume_resp: got rv=%b rdata=%h want 1 a5a5a5e1",
                  data_rvalid, data_rdata);
      end
      tick();
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      test_reset();
      test_inst_only();
      test_contention();
      test_starvation();
      test_store();
      test_cancel();
      test_reset_mid_read();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4, is the number of consecutive data grants allowed while an instruction request waits; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 resetn  input  1  reset, asynchronous assert, active-low.
REQ-004 inst_req  input  1  fetch read request; held with inst_addr stable until inst_gnt.
REQ-005 inst_addr  input  32  fetch byte address.
REQ-006 inst_cancel  input  1  branch-cancel; suppresses the inst response due this cycle.
REQ-007 inst_gnt  output  1  fetch request accepted this cycle.
REQ-008 inst_rvalid  output  1  fetch read data valid this cycle.
REQ-009 inst_rdata  output  32  fetch read data.
REQ-010 data_req  input  1  load/store request; held with data_we/addr/wdata stable until data_gnt.
REQ-011 data_we  input  4  byte write enables; 0 means read.
REQ-012 data_addr  input  32  data byte address.
REQ-013 data_wdata  input  32  store data.
REQ-014 data_gnt  output  1  data request accepted this cycle.
REQ-015 data_rvalid  output  1  load data valid this cycle; never asserted for stores.
REQ-016 data_rdata  output  32  load data.
REQ-017 sram_en  output  1  shared single-port SRAM enable.
REQ-018 sram_we  output  4  SRAM byte write enables.
REQ-019 sram_addr  output  32  SRAM address.
REQ-020 sram_wdata  output  32  SRAM write data.
REQ-021 sram_rdata  input  32  SRAM read data, valid the cycle after a read enable.

Function
REQ-022 The block SHALL issue at most one access per cycle; inst_gnt and data_gnt SHALL never be asserted together.
REQ-023 Grant is combinational: sram_en = inst_gnt | data_gnt; sram_addr/sram_we/sram_wdata SHALL come from the granted requester, with sram_we = 0 for inst grants and all SRAM outputs = 0 when nothing is granted.
REQ-024 Default priority: data_req wins over inst_req.
REQ-025 A 4-bit starve counter SHALL increment (saturating at STARVE_MAX) on each cycle where data_gnt=1 and inst_req=1, and SHALL clear on inst_gnt or on any cycle with inst_req=0.
REQ-026 When the counter equals STARVE_MAX and inst_req=1, inst SHALL win over data_req in that cycle.
REQ-027 Response FSM states: IDLE, RESP_INST, RESP_DATA; next state is RESP_INST after inst_gnt, RESP_DATA after data_gnt with data_we=0, otherwise IDLE; the transition happens from any state, so back-to-back reads are pipelined at one per cycle.
REQ-028 In RESP_INST, inst_rvalid = ~inst_cancel; in RESP_DATA, data_rvalid = 1; read latency is exactly one cycle from grant.
REQ-029 inst_rdata and data_rdata SHALL both pass sram_rdata combinationally; they are meaningful only while the matching rvalid is asserted.
REQ-030 inst_cancel outside RESP_INST SHALL have no effect; it SHALL NOT block a grant in the same cycle.
REQ-031 A store grant SHALL generate no response and leaves the FSM in IDLE unless a read is also granted in that cycle, which REQ-022 excludes.

Reset
REQ-032 While resetn=0: FSM=IDLE, starve counter=0, all gnt/rvalid/sram_en/sram_we outputs = 0, independent of requests.
REQ-033 A response pending when reset asserts SHALL be dropped; the first grant is possible in the first clk edge cycle after resetn deasserts.

Verification
REQ-034 Inst-only read: inst_req=1, addr=0x1C000000 -> inst_gnt=1 and sram_addr=0x1C000000 in cycle 0; inst_rvalid=1 with rdata=sram_rdata in cycle 1.
REQ-035 Contention: inst_req and data_req (read, 0x80) both held -> data_gnt cycle 0, data_rvalid cycle 1; data deasserted -> inst_gnt next cycle.
REQ-036 Starvation (STARVE_MAX=4): inst_req held, data_req held for 10 cycles -> data granted cycles 0-3, inst granted cycle 4, counter back to 0, data resumes cycle 5.
REQ-037 Store: data_we=4'b0011, addr=0x100, wdata=0xDEADBEEF -> sram_we=0011, sram_wdata=0xDEADBEEF in grant cycle; no data_rvalid next cycle.
REQ-038 Cancel: inst granted cycle 0, inst_cancel=1 in cycle 1 -> inst_rvalid=0 in cycle 1; a new inst grant in cycle 1 yields inst_rvalid=1 in cycle 2.
REQ-039 Reset mid-read: data read granted, resetn=0 before next edge -> data_rvalid=0 and all outputs 0 immediately; normal operation resumes after resetn=1.
